// File: rtl/wm_cycle_controller_if.sv
// Signal bundle between the washing-machine cycle controller and its
// environment (user panel, door sensor, phase timer, actuator drivers).
//
// Signal semantics, in one place: every signal is a plain level sampled or
// driven on the rising clock edge. There is no valid/ready handshake. The
// timer flags are qualified by the controller's current phase code, and
// every output is a registered level.
//
// Modports:
//   master - environment side: drives user/sensor/timer inputs, reads outputs
//   slave  - controller side: reads inputs, drives phase code and actuators
interface wm_cycle_controller_if;
  // user panel / sensors / timer flags
  logic       start;
  logic       cancel;
  logic       door_Closed;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;
  // phase code and actuator enables
  logic [2:0] state;
  logic       door_Lock;
  logic       water_Valve;
  logic       heater;
  logic       drain_Pump;
  logic [1:0] motor;
  logic       done;
  logic       error;

  modport master (
    output start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
    input  state, door_Lock, water_Valve, heater, drain_Pump, motor, done, error
  );

  modport slave (
    input  start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
    output state, door_Lock, water_Valve, heater, drain_Pump, motor, done, error
  );
endinterface

// File: rtl/wm_cycle_controller.sv
// Main sequencing FSM of the washing-machine controller.
//
// Steps IDLE -> LOCK -> FILL -> HEAT -> WASH -> RINSE -> SPIN -> DONE. The
// phase timer's flags drive the transitions, and each phase is decoded into
// actuator enables. The FSM also handles start-edge detection, the door
// interlock, user cancel, and a per-phase watchdog.
//
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - wm_cycle_controller_if.slave. Its inputs are start, cancel,
//           door_Closed and the timer flags. Its outputs are the phase code
//           `state`, the actuator enables, done and the sticky error.
//
// All outputs are registered. They are decoded from the next state, so
// they change on the same edge as `state`.
module wm_cycle_controller #(
  parameter int LOCK_CYCLES     = 2,
  parameter int WATCHDOG_CYCLES = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  wm_cycle_controller_if.slave   bus
);

  // Encoding is shared with the phase timer and must not change.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_FILL  = 3'd2,
    ST_HEAT  = 3'd3,
    ST_WASH  = 3'd4,
    ST_RINSE = 3'd5,
    ST_SPIN  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
  localparam logic [7:0] WD_LAST   = 8'(WATCHDOG_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       error_q, error_d;

  logic       door_lock_q, door_lock_d;
  logic       water_valve_q, water_valve_d;
  logic       heater_q, heater_d;
  logic       drain_pump_q, drain_pump_d;
  logic [1:0] motor_q, motor_d;
  logic       done_q, done_d;

  logic start_rise;
  logic advance;
  logic door_open;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      start_q       <= 1'b0;
      error_q       <= 1'b0;
      door_lock_q   <= 1'b0;
      water_valve_q <= 1'b0;
      heater_q      <= 1'b0;
      drain_pump_q  <= 1'b0;
      motor_q       <= 2'b00;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      error_q       <= error_d;
      door_lock_q   <= door_lock_d;
      water_valve_q <= water_valve_d;
      heater_q      <= heater_d;
      drain_pump_q  <= drain_pump_d;
      motor_q       <= motor_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic. The order of tests encodes the priority:
  // cancel, then door fault, then phase advance, then watchdog fault.
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    start_d    = bus.start;
    start_rise = bus.start & ~start_q;
    door_open  = ~bus.door_Closed;

    // Only the flag that belongs to the current phase can advance it.
    advance = 1'b0;
    case (state_q)
      ST_FILL:                     advance = bus.sig_Full;
      ST_HEAT:                     advance = bus.sig_Temperature;
      ST_WASH, ST_RINSE, ST_SPIN:  advance = bus.sig_Completed;
      default:                     advance = 1'b0;
    endcase

    if (bus.cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise && bus.door_Closed) begin
            state_d = ST_LOCK;
            error_d = 1'b0;
          end
        end
        ST_LOCK: begin
          // Opening the door before it is locked is not a fault.
          if (door_open)                state_d = ST_IDLE;
          else if (cnt_q == LOCK_LAST)  state_d = ST_FILL;
        end
        ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN: begin
          if (door_open) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end else if (advance) begin
            state_d = state_e'(state_q + 3'd1);
          end else if (cnt_q == WD_LAST) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (door_open) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The phase counter restarts on entry to each phase. It also times
    // LOCK. It saturates, although a watchdog fault always fires first.
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (cnt_q != 8'hFF))
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;
  end

  // Output decode. It uses the next state so that the registered outputs
  // line up with `state`.
  always_comb begin
    door_lock_d   = 1'b0;
    water_valve_d = 1'b0;
    heater_d      = 1'b0;
    drain_pump_d  = 1'b0;
    motor_d       = 2'b00;
    done_d        = 1'b0;
    case (state_d)
      ST_LOCK:  door_lock_d = 1'b1;
      ST_FILL:  begin door_lock_d = 1'b1; water_valve_d = 1'b1; end
      ST_HEAT:  begin door_lock_d = 1'b1; heater_d = 1'b1; end
      ST_WASH:  begin door_lock_d = 1'b1; motor_d = 2'b01; end
      ST_RINSE: begin door_lock_d = 1'b1; water_valve_d = 1'b1; motor_d = 2'b10; end
      ST_SPIN:  begin door_lock_d = 1'b1; drain_pump_d = 1'b1; motor_d = 2'b11; end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.door_Lock   = door_lock_q;
  assign bus.water_Valve = water_valve_q;
  assign bus.heater      = heater_q;
  assign bus.drain_Pump  = drain_pump_q;
  assign bus.motor       = motor_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: doc/wm_cycle_controller.md
# wm_cycle_controller

Main sequencing FSM of the washing-machine controller. Drives the 3-bit phase code consumed by the phase timer, advances on the timer's `sig_Full`, `sig_Temperature` and `sig_Completed` flags, and decodes each phase into actuator enables. Also owns start-edge detection, door interlocking, user cancel and a per-phase watchdog that aborts a stuck cycle.

## Interface
- `LOCK_CYCLES`, 2: cycles spent in LOCK with `door_Lock` asserted before FILL (valid range 1..15).
- `WATCHDOG_CYCLES`, 20: maximum cycles in any phase 2..6 before a fault (valid range 2..255).
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  user start button (level); only its rising edge is used.
- `cancel`  in  1  user abort (level).
- `door_Closed`  in  1  door sensor, 1 = closed.
- `sig_Full`  in  1  from timer; tank full, ends FILL.
- `sig_Temperature`  in  1  from timer; temperature reached, ends HEAT.
- `sig_Completed`  in  1  from timer; timed phase finished, ends WASH/RINSE/SPIN.
- `state`  out  3  phase code to the timer.
- `door_Lock`, `water_Valve`, `heater`, `drain_Pump`  out  1 each  actuator enables.
- `motor`  out  2  00 off, 01 wash, 10 rinse, 11 spin.
- `done`  out  1  cycle finished.
- `error`  out  1  sticky fault flag.

## Operation
- Encoding (fixed, shared with timer): 0 IDLE, 1 LOCK, 2 FILL_WATER, 3 HEAT_WATER, 4 WASH, 5 RINSE, 6 SPIN, 7 DONE.
- Start edge: `start_q` is `start` registered; `start_rise = start & ~start_q`.
- IDLE -> LOCK on `start_rise & door_Closed`; this also clears `error`. `start_rise` with the door open is ignored.
- LOCK -> FILL after `LOCK_CYCLES` cycles in LOCK. If the door opens during LOCK, go to IDLE with no error.
- FILL -> HEAT on `sig_Full`; HEAT -> WASH on `sig_Temperature`.
- WASH -> RINSE, RINSE -> SPIN and SPIN -> DONE on `sig_Completed`. Flags that do not belong to the current phase are ignored.
- DONE -> IDLE when `door_Closed` = 0.
- Phase counter (8 bits) clears on every state change and increments each cycle in states 1..6. It doubles as the LOCK timer.
- Watchdog fault: in states 2..6, when the counter equals `WATCHDOG_CYCLES-1` and the phase's advance flag is low, set `error`=1 and go to IDLE.
- Door fault: `door_Closed`=0 in states 2..6 sets `error`=1 and goes to IDLE.
- Cancel: `cancel`=1 in any state 1..7 forces IDLE; `error` is unchanged.
- Priority, highest first: reset, cancel, door fault, phase advance, watchdog fault. An advance flag on the expiry cycle therefore wins.
- Output decode per state; unlisted outputs are 0:
  - LOCK: `door_Lock`.
  - FILL: `door_Lock`, `water_Valve`.
  - HEAT: `door_Lock`, `heater`.
  - WASH: `door_Lock`, `motor`=01.
  - RINSE: `door_Lock`, `water_Valve`, `motor`=10.
  - SPIN: `door_Lock`, `drain_Pump`, `motor`=11.
  - DONE: `done`.
- `heater` and `water_Valve` must never be driven outside their listed states.

## Timing
- Reset values: `state`=0; all actuators, `motor`=00, `done`=0, `error`=0; `start_q`=0; counter=0.
- All outputs are registered and update on the same edge as `state`, with no combinational input-to-output path.
- A condition sampled at edge k is reflected on the outputs after edge k.
- Start latency: `start` rises before edge k, so `state`=1 after edge k.
- LOCK lasts exactly `LOCK_CYCLES` cycles; `state`=2 appears `LOCK_CYCLES` edges after entering LOCK.
- Watchdog: entering phase p at edge k with no advance flag gives `state`=0 and `error`=1 after edge k+`WATCHDOG_CYCLES`.
- The counter saturates rather than wrapping; it cannot exceed `WATCHDOG_CYCLES` before a fault fires.
- Reset asserted mid-cycle returns everything to reset values on the next edge, regardless of other inputs.
- A held `start` never retriggers a cycle. Holding `start` through DONE -> IDLE does not restart.

## Test plan
- Nominal cycle with defaults: pulse `start` with the door closed, then assert `sig_Full`, `sig_Temperature` and `sig_Completed` ×3 at the right phases -> state sequence 0,1,1,2,3,4,5,6,7 with decoded outputs per phase, `done`=1; opening the door gives `state`=0.
- Watchdog: hold FILL with `sig_Full`=0 -> exactly 20 cycles after FILL entry `state`=0, `error`=1. A following `start` rise clears `error`.
- Door fault: open the door in WASH -> next cycle `state`=0, `error`=1, `motor`=00. Opening the door in LOCK instead -> `state`=0, `error`=0.
- Cancel in HEAT with `sig_Temperature` asserted in the same cycle -> `state`=0, `heater`=0. `sig_Full` asserted during WASH is ignored.
- Boundary: `sig_Completed` asserted on the watchdog expiry cycle in RINSE -> `state`=6, `error`=0.
- Held `start` plus door open then closed after DONE -> stays at 0. `start_rise` with the door open -> stays at 0.
- Mid-cycle reset in SPIN -> all outputs 0 and `state`=0 next cycle.
